// File: rtl/fft_frame_server.sv
// fft_frame_server
// Ping-pong frame buffer in front of the FFT bit-reversal stage. Incoming audio
// samples fill the write bank while the FFT stage reads the other bank by
// random-address request. Banks swap once a full frame is written and the
// previous frame has been completely served.

module fft_frame_server #(
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int Q      = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [Q:0]   sample_in,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                valid_packet,
    output logic                valid_out,
    output logic signed [Q:0]   data_out,
    output logic                frame_done,
    output logic                overrun,
    output logic                busy
);

    typedef enum logic {W_FILL, W_FULL_WAIT} wr_state_t;
    typedef enum logic {R_IDLE, R_SERVE}     rd_state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;

    logic wr_accept;
    logic last_write;
    logic drop;
    logic serve;
    logic last_serve;
    logic swap;

    // Two banks of N words; the bank bit is the address MSB.
    logic signed [Q:0] mem [0:2*N-1];

    // State register for both the writer and the reader FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= W_FILL;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    // Event decode: accepted writes, served requests, and the bank swap. The swap
    // is taken in the cycle the final request is served so the reader never drops out of SERVE.
    always_comb begin
        wr_accept  = (wr_state == W_FILL) && sample_valid;
        last_write = wr_accept && (wr_cnt == LAST_IDX);
        drop       = (wr_state == W_FULL_WAIT) && sample_valid;
        serve      = (rd_state == R_SERVE) && req_valid;
        last_serve = serve && (rd_cnt == LAST_IDX);
        swap       = 1'b0;
        if (last_write && ((rd_state == R_IDLE) || last_serve)) begin
            swap = 1'b1;
        end
        if ((wr_state == W_FULL_WAIT) && ((rd_state == R_IDLE) || last_serve)) begin
            swap = 1'b1;
        end
    end

    // Next-state logic for the writer and reader FSMs.
    always_comb begin
        wr_state_next = wr_state;
        rd_state_next = rd_state;
        case (wr_state)
            W_FILL:      if (last_write && !swap) wr_state_next = W_FULL_WAIT;
            W_FULL_WAIT: if (swap) wr_state_next = W_FILL;
            default:     wr_state_next = W_FILL;
        endcase
        case (rd_state)
            R_IDLE:  if (swap) rd_state_next = R_SERVE;
            R_SERVE: if (last_serve && !swap) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Busy simply reflects the reader being in SERVE.
    always_comb begin
        busy = (rd_state == R_SERVE);
    end

    // Sample storage write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_cnt}] <= sample_in;
        end
    end

    // Counters, bank pointers, synchronous read port and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            valid_packet <= 1'b0;
            valid_out    <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            data_out     <= '0;
        end else begin
            valid_packet <= swap;
            valid_out    <= serve;
            frame_done   <= last_serve;
            overrun      <= drop;
            if (serve) begin
                data_out <= mem[{rd_bank, req_addr}];
                rd_cnt   <= rd_cnt + ADDR_W'(1);
            end
            if (wr_accept) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
            if (swap) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_server.sv
// tb_fft_frame_server
// Directed bench for the ping-pong frame server: a short vector table after the
// first frame, plus hand-written sequences for overrun, coincident swap,
// back-to-back bit-reversed reads and mid-frame reset.

module tb_fft_frame_server;

    logic               clk;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic               req_valid;
    logic [7:0]         req_addr;
    logic               valid_packet;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               frame_done;
    logic               overrun;
    logic               busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic               sv;
        logic signed [15:0] s;
        logic               rv;
        logic [7:0]         addr;
        logic               vp;
        logic               vo;
        logic               fd;
        logic               ov;
        logic               bz;
        logic               chk;
        logic signed [15:0] data;
    } vec_t;

    vec_t vecs [5];

    fft_frame_server #(.N(256), .ADDR_W(8), .Q(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .valid_packet (valid_packet),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .busy         (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic sv, input logic signed [15:0] s,
                                 input logic rv, input logic [7:0] addr);
        sample_valid = sv;
        sample_in    = s;
        req_valid    = rv;
        req_addr     = addr;
        @(posedge clk);
        #1;
    endtask

    // Compare the flag outputs, and optionally data_out, against expectations.
    task automatic checkOutput(input string name, input logic e_vp, input logic e_vo,
                               input logic e_fd, input logic e_ov, input logic e_bz,
                               input logic chk, input logic signed [15:0] e_data);
        tests++;
        if ({valid_packet, valid_out, frame_done, overrun, busy} !== {e_vp, e_vo, e_fd, e_ov, e_bz}) begin
            fails++;
            $display("[TB] FAIL %s: vp/vo/fd/ov/busy got %b expected %b", name,
                     {valid_packet, valid_out, frame_done, overrun, busy},
                     {e_vp, e_vo, e_fd, e_ov, e_bz});
        end
        if (chk) begin
            tests++;
            if (data_out !== e_data) begin
                fails++;
                $display("[TB] FAIL %s: data_out got %0d expected %0d", name, data_out, e_data);
            end
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] a);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = a[7-b];
        return r;
    endfunction

    // Main directed sequence.
    initial begin
        // Reads of frame 1 (samples 0..255) right after it is published.
        vecs[0] = '{1'b0, 16'sd0, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd0};
        vecs[1] = '{1'b0, 16'sd0, 1'b1, 8'd128, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd128};
        vecs[2] = '{1'b0, 16'sd0, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd255};
        vecs[3] = '{1'b0, 16'sd0, 1'b0, 8'd17,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd255};
        vecs[4] = '{1'b0, 16'sd0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd255};

        reset = 1'b1;
        applyStimulus(1'b0, 16'sd0, 1'b0, 8'd0);
        applyStimulus(1'b0, 16'sd0, 1'b0, 8'd0);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'sd0);
        reset = 1'b0;

        // Requests while the reader is idle are ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'sd0, 1'b1, 8'(i * 7));
            checkOutput($sformatf("idle_req[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'sd0);
        end

        // Frame 1: samples 0..255, reader idle, so it is published immediately.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 8'd0);
            checkOutput($sformatf("frame1[%0d]", i), (i == 255), 1'b0, 1'b0, 1'b0, (i == 255), 1'b0, 16'sd0);
        end

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].sv, vecs[v].s, vecs[v].rv, vecs[v].addr);
            checkOutput($sformatf("vec[%0d]", v), vecs[v].vp, vecs[v].vo, vecs[v].fd,
                        vecs[v].ov, vecs[v].bz, vecs[v].chk, vecs[v].data);
        end

        // Frame 2 (1000+i) written while frame 1 is still being served.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(1000 + i), 1'b0, 8'd0);
            checkOutput($sformatf("frame2[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'sd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'sd7, 1'b0, 8'd0);
            checkOutput($sformatf("overrun[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'sd0);
        end
        // Remaining 253 requests of frame 1; the last one completes it and swaps.
        for (int i = 3; i < 256; i++) begin
            applyStimulus(1'b0, 16'sd0, 1'b1, 8'(i));
            checkOutput($sformatf("serve1[%0d]", i), (i == 255), 1'b1, (i == 255), 1'b0, 1'b1, 1'b1, 16'(i));
        end
        applyStimulus(1'b0, 16'sd0, 1'b1, 8'd5);
        checkOutput("frame2_addr5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'sd1005);

        // Frame 3 (2000+i): its last write coincides with frame 2's last request.
        for (int j = 0; j < 256; j++) begin
            applyStimulus(1'b1, 16'(2000 + j), (j > 0), 8'(j));
            checkOutput($sformatf("coincide[%0d]", j), (j == 255), (j > 0), (j == 255),
                        1'b0, 1'b1, (j > 0), 16'(1000 + j));
        end

        // 256 back-to-back bit-reversed reads of frame 3; reader idles afterwards.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 16'sd0, 1'b1, bitrev(8'(i)));
            checkOutput($sformatf("b2b[%0d]", i), 1'b0, 1'b1, (i == 255), 1'b0, (i != 255),
                        1'b1, 16'(2000 + int'(bitrev(8'(i)))));
        end
        applyStimulus(1'b0, 16'sd0, 1'b1, 8'd3);
        checkOutput("after_b2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'sd0);

        // Frame 4 (3000+i), then 100 samples of frame 5 with 40 concurrent reads.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(3000 + i), 1'b0, 8'd0);
            checkOutput($sformatf("frame4[%0d]", i), (i == 255), 1'b0, 1'b0, 1'b0, (i == 255), 1'b0, 16'sd0);
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 16'(4000 + i), (i < 40), 8'(i));
            checkOutput($sformatf("partial[%0d]", i), 1'b0, (i < 40), 1'b0, 1'b0, 1'b1,
                        (i < 40), 16'(3000 + i));
        end

        // Mid-frame reset discards everything, even with inputs active.
        reset = 1'b1;
        applyStimulus(1'b1, 16'sd99, 1'b1, 8'd1);
        checkOutput("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'sd0);
        reset = 1'b0;

        // Fresh frame (5000+i) after reset.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(5000 + i), 1'b0, 8'd0);
            checkOutput($sformatf("frame5[%0d]", i), (i == 255), 1'b0, 1'b0, 1'b0, (i == 255), 1'b0, 16'sd0);
        end
        for (int k = 0; k < 4; k++) begin
            int a;
            a = (k == 0) ? 0 : (k == 1) ? 99 : (k == 2) ? 200 : 255;
            applyStimulus(1'b0, 16'sd0, 1'b1, 8'(a));
            checkOutput($sformatf("frame5_rd[%0d]", a), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'(5000 + a));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
